// File: rtl/alu_reg32.sv
// Two-operand ALU (add/sub/and/or) with combinational result and flags,
// plus a load-enabled result register with synchronous clear.
module alu_reg32 #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             En,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [1:0]       Aluc,
    output logic [WIDTH-1:0] R,
    output logic             Z,
    output logic             V,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             Zq
);

    localparam int MSB = WIDTH - 1;

    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] addsub;

    // Subtract shares the adder: X + ~Y + 1.
    assign sub    = Aluc[0];
    assign b_eff  = sub ? ~Y : Y;
    assign addsub = X + b_eff + {{(WIDTH-1){1'b0}}, sub};

    always_comb begin
        R = '0;
        V = 1'b0;
        unique case (Aluc)
            2'b00, 2'b01: begin
                R = addsub;
                // Operands of equal sign into the adder yielding a different sign.
                V = (X[MSB] == b_eff[MSB]) && (addsub[MSB] != X[MSB]);
            end
            2'b10: R = X & Y;
            2'b11: R = X | Y;
            default: R = '0;
        endcase
    end

    assign Z = (R == '0);

    always_ff @(posedge Clk) begin
        if (Clr) begin
            Q  <= '0;
            Zq <= 1'b1;
        end else if (En) begin
            Q  <= R;
            Zq <= Z;
        end
    end

    assign Qn = ~Q;

endmodule

// File: tb/tb_alu_reg32.sv
// Randomized bench for alu_reg32: signed-arithmetic reference model checked
// every cycle, plus literal vectors that pin the model and reset/hold behaviour.
module tb_alu_reg32;

    logic        Clk;
    logic        Clr;
    logic        En;
    logic [31:0] X;
    logic [31:0] Y;
    logic [1:0]  Aluc;
    logic [31:0] R;
    logic        Z;
    logic        V;
    logic [31:0] Q;
    logic [31:0] Qn;
    logic        Zq;

    int n_checks = 0;
    int n_fail   = 0;

    alu_reg32 #(.WIDTH(32)) dut (
        .Clk(Clk), .Clr(Clr), .En(En), .X(X), .Y(Y), .Aluc(Aluc),
        .R(R), .Z(Z), .V(V), .Q(Q), .Qn(Qn), .Zq(Zq)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: arithmetic done on wide signed integers, overflow = out of 32-bit range.
    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  input logic [1:0] op, output logic [31:0] r,
                                  output logic z, output logic v);
        longint sx, sy, s;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        s  = 0;
        v  = 1'b0;
        case (op)
            2'd0: s = sx + sy;
            2'd1: s = sx - sy;
            default: s = 0;
        endcase
        if (op == 2'd2)      r = x & y;
        else if (op == 2'd3) r = x | y;
        else begin
            r = s[31:0];
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        z = (r == 32'h0);
    endfunction

    // Model register state
    logic [31:0] eq;
    logic        ezq;
    logic        qvalid = 1'b0;
    logic [31:0] mr;
    logic        mz, mv;

    always @(posedge Clk) begin
        model(X, Y, Aluc, mr, mz, mv);
        if (Clr) begin
            eq     <= 32'h0;
            ezq    <= 1'b1;
            qvalid <= 1'b1;
        end else if (En) begin
            eq  <= mr;
            ezq <= mz;
        end
    end

    logic [31:0] cr;
    logic        cz, cv;

    always @(negedge Clk) begin
        model(X, Y, Aluc, cr, cz, cv);
        chk("R", R, cr);
        chk("Z", {31'b0, Z}, {31'b0, cz});
        chk("V", {31'b0, V}, {31'b0, cv});
        if (qvalid) begin
            chk("Q", Q, eq);
            chk("Qn", Qn, ~eq);
            chk("Zq", {31'b0, Zq}, {31'b0, ezq});
        end
    end

    task automatic comb_lit(input string nm, input logic [31:0] x, input logic [31:0] y,
                            input logic [1:0] op, input logic [31:0] er,
                            input logic ez, input logic ev);
        X = x; Y = y; Aluc = op;
        #1;
        chk({nm, ".R"}, R, er);
        chk({nm, ".Z"}, {31'b0, Z}, {31'b0, ez});
        chk({nm, ".V"}, {31'b0, V}, {31'b0, ev});
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] e;
        case ($urandom_range(0, 7))
            0: e = 32'h0;
            1: e = 32'hFFFFFFFF;
            2: e = 32'h80000000;
            3: e = 32'h7FFFFFFF;
            4: e = 32'h1;
            default: e = $urandom;
        endcase
        return e;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        Clr = 1'b1; En = 1'b1; X = 32'h1234; Y = 32'h5678; Aluc = 2'b00;
        @(posedge Clk); #1;
        chk("rst.Q", Q, 32'h0);
        chk("rst.Qn", Qn, 32'hFFFFFFFF);
        chk("rst.Zq", {31'b0, Zq}, 32'h1);

        // Combinational vectors; Clr held high here must not affect R/Z/V
        comb_lit("and_CA", 32'hC, 32'hA, 2'b10, 32'h8, 1'b0, 1'b0);
        Clr = 1'b0; En = 1'b0;
        comb_lit("or_CA", 32'hC, 32'hA, 2'b11, 32'hE, 1'b0, 1'b0);
        comb_lit("add_CA", 32'hC, 32'hA, 2'b00, 32'h16, 1'b0, 1'b0);
        comb_lit("sub_CA", 32'hC, 32'hA, 2'b01, 32'h2, 1'b0, 1'b0);
        comb_lit("add_ovf", 32'h7FFFFFFF, 32'h1, 2'b00, 32'h80000000, 1'b0, 1'b1);
        comb_lit("sub_ovf", 32'h80000000, 32'h1, 2'b01, 32'h7FFFFFFF, 1'b0, 1'b1);
        comb_lit("sub_eq", 32'h12345678, 32'h12345678, 2'b01, 32'h0, 1'b1, 1'b0);
        comb_lit("add_wrap", 32'hFFFFFFFF, 32'h1, 2'b00, 32'h0, 1'b1, 1'b0);
        comb_lit("or_ovfpat", 32'h7FFFFFFF, 32'h1, 2'b11, 32'h7FFFFFFF, 1'b0, 1'b0);

        // Load AND result, then hold for 3 edges with changing operands
        @(posedge Clk); #1;
        X = 32'hC; Y = 32'hA; Aluc = 2'b10; En = 1'b1;
        @(posedge Clk); #1;
        chk("load.Q", Q, 32'h8);
        chk("load.Qn", Qn, 32'hFFFFFFF7);
        chk("load.Zq", {31'b0, Zq}, 32'h0);
        En = 1'b0;
        for (int i = 0; i < 3; i++) begin
            X = $urandom; Y = $urandom; Aluc = 2'($urandom);
            @(posedge Clk); #1;
        end
        chk("hold.Q", Q, 32'h8);

        // Clear wins over enable
        Clr = 1'b1; En = 1'b1; X = 32'h5; Y = 32'h6; Aluc = 2'b00;
        @(posedge Clk); #1;
        chk("clrpri.Q", Q, 32'h0);
        chk("clrpri.Qn", Qn, 32'hFFFFFFFF);
        chk("clrpri.Zq", {31'b0, Zq}, 32'h1);

        // First edge after release loads R
        Clr = 1'b0; X = 32'hC; Y = 32'hA; Aluc = 2'b00;
        @(posedge Clk); #1;
        chk("release.Q", Q, 32'h16);

        // Clr pulse between edges changes nothing
        En = 1'b0;
        Clr = 1'b1; #1; Clr = 1'b0; #1;
        chk("pulse.Q", Q, 32'h16);
        chk("pulse.Zq", {31'b0, Zq}, 32'h0);
        En = 1'b1; X = 32'h5; Y = 32'h3; Aluc = 2'b01;
        @(posedge Clk); #1;
        chk("afterpulse.Q", Q, 32'h2);

        // Randomized traffic with occasional mid-cycle operand changes
        for (int i = 0; i < 3000; i++) begin
            X    = pick();
            Y    = ($urandom_range(0, 5) == 0) ? X : pick();
            Aluc = 2'($urandom);
            En   = ($urandom_range(0, 3) != 0);
            Clr  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) begin
                #2;
                X = pick();
            end
            @(posedge Clk); #1;
        end

        @(negedge Clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
